// File: rtl/paging_mapper.sv
// paging_mapper: SMS mapper register block and address translator.
//
// Takes a paging request from the Z80 paging handler when the CPU writes FFFC-FFFF. It captures
// the write and commits it to the control/bank registers. It then holds the CPU for DRAIN_CYCLES
// cycles so prefetched instructions drain, and pulses flush0 to clear the upstream request.
// CPU addresses are translated combinationally to ROM, cartridge-RAM and system-RAM selects.
//
// Optional feature: define CART_RAM_EN to enable cartridge-RAM mapping at 8000-BFFF (ctrl[3:2]).
// Without it, cram_sel/cram_addr are tied low and 8000-BFFF always maps to ROM bank2.
//
// Ports:
//   CLK, RST       clock; synchronous active-low reset
//   paging_RQ      mapper-write request, held high upstream until flush0
//   MREQ, Rd_Wr    CPU memory request (active-high), 1=read / 0=write
//   addr, wdata    CPU address and write data
//   flush0         one-cycle pulse clearing the upstream request
//   stall          CPU hold
//   rom_sel/addr   ROM select and physical byte address
//   cram_sel/addr  cartridge RAM select and address {bank bit, addr[12:0]}
//   sram_sel/addr  system RAM select and address (8KB mirrored over C000-FFFF)
//   ctrl_q         FFFC control register, for debug
module paging_mapper #(
  parameter int unsigned ROM_AW       = 19,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              paging_RQ,
  input  logic              MREQ,
  input  logic              Rd_Wr,
  input  logic [15:0]       addr,
  input  logic [7:0]        wdata,
  output logic              flush0,
  output logic              stall,
  output logic              rom_sel,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              cram_sel,
  output logic [13:0]       cram_addr,
  output logic              sram_sel,
  output logic [12:0]       sram_addr,
  output logic [7:0]        ctrl_q
);

  localparam int unsigned BankW     = ROM_AW - 14;
  localparam logic [3:0]  DrainLoad = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StCommit, StDrain, StFlush} state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       cnt_q, cnt_d;
  // Bank registers keep only the implemented bank bits, so out-of-range numbers wrap on write.
  logic [BankW-1:0] bank0_q, bank1_q, bank2_q;

  logic             cram_map;
  logic [13:0]      cram_page;

  // Next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    stall   = 1'b1;
    flush0  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The request is visible in the same cycle as the CPU write, so hold the CPU immediately.
        stall = paging_RQ;
        if (paging_RQ) begin
          idx_d   = addr[1:0];
          data_d  = wdata;
          state_d = StCommit;
        end
      end
      StCommit: begin
        if (DRAIN_CYCLES == 0) begin
          state_d = StFlush;
        end else begin
          cnt_d   = DrainLoad;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (cnt_q == 4'd0) state_d = StFlush;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StFlush: begin
        flush0  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      data_q  <= 8'd0;
      cnt_q   <= 4'd0;
      ctrl_q  <= 8'h00;
      bank0_q <= BankW'(0);
      bank1_q <= BankW'(1);
      bank2_q <= BankW'(2);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      if (state_q == StCommit) begin
        unique case (idx_q)
          2'd0:    ctrl_q  <= data_q;
          2'd1:    bank0_q <= BankW'(data_q);
          2'd2:    bank1_q <= BankW'(data_q);
          default: bank2_q <= BankW'(data_q);
        endcase
      end
    end
  end

`ifdef CART_RAM_EN
  assign cram_map  = ctrl_q[3];
  assign cram_page = {ctrl_q[2], addr[12:0]};
`else
  assign cram_map  = 1'b0;
  assign cram_page = 14'd0;
`endif

  // Address translation
  always_comb begin
    rom_sel   = 1'b0;
    rom_addr  = '0;
    cram_sel  = 1'b0;
    cram_addr = cram_page;
    sram_sel  = 1'b0;
    sram_addr = addr[12:0];
    unique case (addr[15:14])
      2'b00: begin
        // First 1KB holds the interrupt vectors and is never paged.
        if (addr[13:10] == 4'd0) rom_addr = ROM_AW'(addr[9:0]);
        else                     rom_addr = {bank0_q, addr[13:0]};
      end
      2'b01:   rom_addr = {bank1_q, addr[13:0]};
      2'b10:   rom_addr = {bank2_q, addr[13:0]};
      default: rom_addr = '0;
    endcase
    if (MREQ) begin
      if (addr[15:14] == 2'b11)                 sram_sel = 1'b1;
      else if (addr[15:14] == 2'b10 && cram_map) cram_sel = 1'b1;
      else                                       rom_sel  = Rd_Wr;
    end
  end

endmodule

// File: tb/tb_paging_mapper.sv
module tb_paging_mapper;

  localparam int unsigned RomAw  = 19;
  localparam int unsigned Drain  = 2;
  localparam int unsigned NBanks = 1 << (RomAw - 14);
`ifdef CART_RAM_EN
  localparam bit Cart = 1'b1;
`else
  localparam bit Cart = 1'b0;
`endif

  logic             CLK;
  logic             RST;
  logic             paging_RQ;
  logic             MREQ;
  logic             Rd_Wr;
  logic [15:0]      addr;
  logic [7:0]       wdata;
  logic             flush0;
  logic             stall;
  logic             rom_sel;
  logic [RomAw-1:0] rom_addr;
  logic             cram_sel;
  logic [13:0]      cram_addr;
  logic             sram_sel;
  logic [12:0]      sram_addr;
  logic [7:0]       ctrl_q;

  paging_mapper #(
    .ROM_AW      (RomAw),
    .DRAIN_CYCLES(Drain)
  ) u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .paging_RQ(paging_RQ),
    .MREQ     (MREQ),
    .Rd_Wr    (Rd_Wr),
    .addr     (addr),
    .wdata    (wdata),
    .flush0   (flush0),
    .stall    (stall),
    .rom_sel  (rom_sel),
    .rom_addr (rom_addr),
    .cram_sel (cram_sel),
    .cram_addr(cram_addr),
    .sram_sel (sram_sel),
    .sram_addr(sram_addr),
    .ctrl_q   (ctrl_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register file as written by the CPU (index 0=ctrl, 1..3=bank0..bank2).
  logic [7:0]  m_reg [4];
  logic [31:0] e_rom_sel, e_rom_addr, e_cram_sel, e_cram_addr, e_sram_sel, e_sram_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_reg[0] = 8'h00;
    m_reg[1] = 8'd0;
    m_reg[2] = 8'd1;
    m_reg[3] = 8'd2;
  endtask

  task automatic model_xlate(input logic [15:0] a, input logic rw, input logic mreq);
    int unsigned bank;
    e_rom_sel = 0; e_rom_addr = 0; e_cram_sel = 0; e_cram_addr = 0;
    e_sram_sel = 0; e_sram_addr = 0;
    if (!mreq) return;
    if (a >= 16'hC000) begin
      e_sram_sel  = 1;
      e_sram_addr = 32'(a) % 8192;
      return;
    end
    if (a >= 16'h8000 && Cart && m_reg[0][3]) begin
      e_cram_sel  = 1;
      e_cram_addr = (m_reg[0][2] ? 8192 : 0) + 32'(a) % 8192;
      return;
    end
    e_rom_sel = 32'(rw);
    if (a < 16'h0400) begin
      e_rom_addr = 32'(a);
    end else begin
      bank       = 32'(m_reg[1 + 32'(a) / 16384]) % NBanks;
      e_rom_addr = bank * 16384 + 32'(a) % 16384;
    end
  endtask

  task automatic check_xlate();
    model_xlate(addr, Rd_Wr, MREQ);
    check("rom_sel", 32'(rom_sel), e_rom_sel);
    if (e_rom_sel != 0) check("rom_addr", 32'(rom_addr), e_rom_addr);
    check("cram_sel", 32'(cram_sel), e_cram_sel);
    if (e_cram_sel != 0) check("cram_addr", 32'(cram_addr), e_cram_addr);
    check("sram_sel", 32'(sram_sel), e_sram_sel);
    if (e_sram_sel != 0) check("sram_addr", 32'(sram_addr), e_sram_addr);
    check("ctrl_q", 32'(ctrl_q), 32'(m_reg[0]));
  endtask

  task automatic read_check(input logic [15:0] a, input logic rw, input logic mreq);
    @(negedge CLK);
    paging_RQ = 1'b0;
    addr      = a;
    Rd_Wr     = rw;
    MREQ      = mreq;
    wdata     = 8'($urandom);
    #1;
    check("idle_stall", 32'(stall), 0);
    check("idle_flush", 32'(flush0), 0);
    check_xlate();
  endtask

  // Mapper write from the capture cycle T through FLUSH. abort_at>0 asserts reset in that cycle.
  task automatic do_write(input logic [1:0] idx, input logic [7:0] data, input int abort_at);
    @(negedge CLK);
    paging_RQ = 1'b1;
    MREQ      = 1'b1;
    Rd_Wr     = 1'b0;
    addr      = 16'hFFFC | 16'(idx);
    wdata     = data;
    #1;
    check("cap_stall", 32'(stall), 1);
    check("cap_flush", 32'(flush0), 0);
    for (int k = 1; k <= 2 + int'(Drain); k++) begin
      @(negedge CLK);
      if (k == abort_at) begin
        RST       = 1'b0;
        paging_RQ = 1'b0;
        @(negedge CLK);
        #1;
        check("abort_stall", 32'(stall), 0);
        check("abort_flush", 32'(flush0), 0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("abort_stall2", 32'(stall), 0);
        check("abort_flush2", 32'(flush0), 0);
        model_reset();
        return;
      end
      // Bus moves on after T; the captured write must not be resampled.
      addr  = 16'($urandom);
      wdata = 8'($urandom);
      MREQ  = 1'($urandom);
      Rd_Wr = 1'($urandom);
      if (k == 2) m_reg[idx] = data;
      #1;
      check("seq_stall", 32'(stall), 1);
      check("seq_flush", 32'(flush0), (k == 2 + int'(Drain)) ? 1 : 0);
      check_xlate();
    end
  endtask

  initial begin
    RST       = 1'b0;
    paging_RQ = 1'b0;
    MREQ      = 1'b0;
    Rd_Wr     = 1'b1;
    addr      = 16'h0000;
    wdata     = 8'h00;
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    check("rst_ctrl", 32'(ctrl_q), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_flush", 32'(flush0), 0);
    RST = 1'b1;

    read_check(16'h4000, 1'b1, 1'b1);
    check("rd4000", 32'(rom_addr), 32'h04000);
    read_check(16'h8123, 1'b1, 1'b1);
    check("rd8123", 32'(rom_addr), 32'h08123);

    do_write(2'd2, 8'h05, 0);
    read_check(16'h4010, 1'b1, 1'b1);
    check("rd4010", 32'(rom_addr), 32'h14010);

    do_write(2'd3, 8'h25, 0);
    read_check(16'h8000, 1'b1, 1'b1);
    check("rd8000_mask", 32'(rom_addr), 32'h14000);

    do_write(2'd0, 8'h0C, 0);
    read_check(16'h9ABC, 1'b1, 1'b1);
    read_check(16'h9ABC, 1'b0, 1'b1);
    read_check(16'h4000, 1'b0, 1'b1);
    read_check(16'h0123, 1'b1, 1'b0);
    read_check(16'hFFFD, 1'b1, 1'b1);
    read_check(16'hE001, 1'b0, 1'b1);

    do_write(2'd1, 8'h07, 2);
    read_check(16'h0500, 1'b1, 1'b1);
    check("rd0500_abort", 32'(rom_addr), 32'h00500);

    do_write(2'd1, 8'h03, 0);
    do_write(2'd2, 8'h04, 0);
    read_check(16'h0000, 1'b1, 1'b1);
    check("rd0000_fixed", 32'(rom_addr), 32'h00000);
    read_check(16'h0400, 1'b1, 1'b1);
    read_check(16'h7FFF, 1'b1, 1'b1);

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) do_write(2'($urandom), 8'($urandom), 0);
      else read_check(16'($urandom), 1'($urandom), 1'($urandom_range(0, 4) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
